// File: rtl/axi_10g_ethernet_0_arp_tx.sv
// ARP reply/request frame generator for the 10G MAC TX AXI-Stream path.
// Emits a fixed 60-byte frame as eight 64-bit beats, byte 0 on tdata[7:0].
module axi_10g_ethernet_0_arp_tx #(
  parameter logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20}
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        tx_arp_en,
  input  logic [47:0] arp_src_mac,
  input  logic [31:0] arp_src_ip,
  input  logic        arp_req_en,
  input  logic [31:0] arp_req_ip,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic {IDLE, SEND} state_t;

  // Local identity in wire order (byte 0 in the low bits)
  localparam logic [47:0] BMAC_W = {
    BOARD_MAC[7:0],   BOARD_MAC[15:8],  BOARD_MAC[23:16],
    BOARD_MAC[31:24], BOARD_MAC[39:32], BOARD_MAC[47:40]
  };
  localparam logic [31:0] BIP_W = {
    BOARD_IP[7:0], BOARD_IP[15:8], BOARD_IP[23:16], BOARD_IP[31:24]
  };

  state_t      state;
  logic        rep_pend;
  logic        req_pend;
  logic [47:0] rep_mac;
  logic [31:0] rep_ip;
  logic [31:0] req_ip;
  logic        f_rep;
  logic [47:0] f_mac;
  logic [31:0] f_ip;
  logic [2:0]  cnt;

  logic        s_rep;
  logic [47:0] s_mac;
  logic [31:0] s_ip;
  logic [2:0]  s_idx;
  logic [47:0] dmac;
  logic [47:0] tmac;
  logic [7:0]  op;
  logic [511:0] frame;
  logic [63:0] beat;

  // In IDLE the next frame comes straight from a pending slot
  always_comb begin
    s_rep = f_rep;
    s_mac = f_mac;
    s_ip  = f_ip;
    s_idx = cnt + 3'd1;
    if (state == IDLE) begin
      s_idx = 3'd0;
      if (rep_pend) begin
        s_rep = 1'b1;
        s_mac = rep_mac;
        s_ip  = rep_ip;
      end else begin
        s_rep = 1'b0;
        s_mac = '0;
        s_ip  = req_ip;
      end
    end
  end

  assign dmac = s_rep ? s_mac : '1;
  assign tmac = s_rep ? s_mac : '0;
  assign op   = s_rep ? 8'h02 : 8'h01;

  assign frame = {
    32'h0, 144'h0,
    s_ip, tmac, BIP_W, BMAC_W,
    op, 8'h00,
    8'h04, 8'h06, 8'h00, 8'h08,
    8'h01, 8'h00, 8'h06, 8'h08,
    BMAC_W, dmac
  };

  assign beat = frame[{s_idx, 6'd0} +: 64];
  assign busy = (state == SEND) | rep_pend | req_pend;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= IDLE;
      rep_pend       <= 1'b0;
      req_pend       <= 1'b0;
      rep_mac        <= '0;
      rep_ip         <= '0;
      req_ip         <= '0;
      f_rep          <= 1'b0;
      f_mac          <= '0;
      f_ip           <= '0;
      cnt            <= '0;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rep_pend | req_pend) begin
            f_rep          <= s_rep;
            f_mac          <= s_mac;
            f_ip           <= s_ip;
            cnt            <= 3'd0;
            tx_axis_tdata  <= beat;
            tx_axis_tkeep  <= 8'hff;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tvalid <= 1'b1;
            state          <= SEND;
            if (rep_pend) rep_pend <= 1'b0;
            else          req_pend <= 1'b0;
          end
        end
        SEND: begin
          if (tx_axis_tvalid & tx_axis_tready) begin
            if (cnt == 3'd7) begin
              tx_axis_tvalid <= 1'b0;
              tx_axis_tlast  <= 1'b0;
              tx_axis_tkeep  <= '0;
              tx_axis_tdata  <= '0;
              tx_done        <= 1'b1;
              state          <= IDLE;
            end else begin
              cnt           <= cnt + 3'd1;
              tx_axis_tdata <= beat;
              tx_axis_tkeep <= (cnt == 3'd6) ? 8'h0f : 8'hff;
              tx_axis_tlast <= (cnt == 3'd6);
            end
          end
        end
      endcase
      // New triggers win over the slot clear on the same edge
      if (tx_arp_en) begin
        rep_pend <= 1'b1;
        rep_mac  <= arp_src_mac;
        rep_ip   <= arp_src_ip;
      end
      if (arp_req_en) begin
        req_pend <= 1'b1;
        req_ip   <= {arp_req_ip[7:0], arp_req_ip[15:8],
                     arp_req_ip[23:16], arp_req_ip[31:24]};
      end
    end
  end

endmodule
